// File: rtl/multi_pit.sv
// Multi-channel programmable interval timer: per-channel reload, prescaler,
// one-shot/periodic mode, sticky pending/overrun flags and count readback.
module multi_pit #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_reload,
  input  logic [PRE_W-1:0]  wr_prescale,
  input  logic              wr_periodic,
  input  logic              wr_run,
  input  logic [NUM_CH-1:0] irq_ack,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count,
  output logic [NUM_CH-1:0] irq_pulse,
  output logic [NUM_CH-1:0] irq_pending,
  output logic [NUM_CH-1:0] irq_overrun,
  output logic              irq
);

  logic [CNT_W-1:0] count_all [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] reload_q;
    logic [PRE_W-1:0] prescale_q;
    logic             periodic_q;
    logic             run_q;
    logic [CNT_W-1:0] count_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic             pending_q;
    logic             overrun_q;
    logic             pulse_q;
    logic             wr_hit;
    logic             tick;
    logic             expire;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign wr_hit = wr_en && (wr_ch == CH_W'(g));
    assign tick   = run_q && (pre_cnt_q == prescale_q);
    assign expire = tick && (count_q == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        reload_q   <= '0;
        prescale_q <= '0;
        periodic_q <= 1'b0;
        run_q      <= 1'b0;
        count_q    <= '0;
        pre_cnt_q  <= '0;
        pending_q  <= 1'b0;
        overrun_q  <= 1'b0;
        pulse_q    <= 1'b0;
      end else if (wr_hit) begin
        // A write overrides any tick or ack arriving on the same edge.
        reload_q   <= wr_reload;
        prescale_q <= wr_prescale;
        periodic_q <= wr_periodic;
        run_q      <= wr_run;
        count_q    <= wr_reload;
        pre_cnt_q  <= '0;
        pending_q  <= 1'b0;
        overrun_q  <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        pulse_q <= expire;
        if (run_q) begin
          pre_cnt_q <= tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
        if (tick) begin
          if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
          end else if (periodic_q) begin
            count_q <= reload_q;
          end else begin
            run_q <= 1'b0;
          end
        end
        // An ack coinciding with an expiry is absorbed by the new expiry.
        if (expire) begin
          pending_q <= 1'b1;
          if (pending_q && !irq_ack[g]) begin
            overrun_q <= 1'b1;
          end
        end else if (irq_ack[g]) begin
          pending_q <= 1'b0;
          overrun_q <= 1'b0;
        end
      end
    end

    assign count_all[g]   = count_q;
    assign irq_pulse[g]   = pulse_q;
    assign irq_pending[g] = pending_q;
    assign irq_overrun[g] = overrun_q;
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_count = count_all[i];
      end
    end
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_multi_pit.sv
// Bench for multi_pit: directed scenarios plus random traffic, all checked
// against an elapsed-cycle model of each channel.
module tb_multi_pit;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_reload;
  logic [PRE_W-1:0]  wr_prescale;
  logic              wr_periodic;
  logic              wr_run;
  logic [NUM_CH-1:0] irq_ack;
  logic [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_count;
  logic [NUM_CH-1:0] irq_pulse;
  logic [NUM_CH-1:0] irq_pending;
  logic [NUM_CH-1:0] irq_overrun;
  logic              irq;

  always #5 clk = ~clk;

  multi_pit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_reload(wr_reload), .wr_prescale(wr_prescale),
    .wr_periodic(wr_periodic), .wr_run(wr_run), .irq_ack(irq_ack),
    .rd_ch(rd_ch), .rd_count(rd_count), .irq_pulse(irq_pulse),
    .irq_pending(irq_pending), .irq_overrun(irq_overrun), .irq(irq)
  );

  // Model: a running channel is described only by cycles elapsed since its
  // period began; expiry happens when elapsed reaches (reload+1)*(pre+1).
  int m_reload  [NUM_CH];
  int m_pre     [NUM_CH];
  int m_elapsed [NUM_CH];
  bit m_periodic[NUM_CH];
  bit m_run     [NUM_CH];
  bit m_done    [NUM_CH];
  bit m_pending [NUM_CH];
  bit m_overrun [NUM_CH];
  bit m_pulse   [NUM_CH];

  int vectors = 0;
  int miscompares = 0;

  function automatic int m_count(int ch);
    if (m_done[ch]) return 0;
    return m_reload[ch] - m_elapsed[ch] / (m_pre[ch] + 1);
  endfunction

  function automatic int m_period(int ch);
    return (m_reload[ch] + 1) * (m_pre[ch] + 1);
  endfunction

  task automatic model_edge(input bit r, input bit we, input int wch, input int wrl,
                            input int wps, input bit wper, input bit wrun,
                            input logic [NUM_CH-1:0] ack);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r) begin
        m_reload[ch] = 0; m_pre[ch] = 0; m_elapsed[ch] = 0; m_periodic[ch] = 0;
        m_run[ch] = 0; m_done[ch] = 0; m_pending[ch] = 0; m_overrun[ch] = 0;
        m_pulse[ch] = 0;
      end else if (we && wch == ch) begin
        m_reload[ch] = wrl; m_pre[ch] = wps; m_periodic[ch] = wper; m_run[ch] = wrun;
        m_elapsed[ch] = 0; m_done[ch] = 0; m_pending[ch] = 0; m_overrun[ch] = 0;
        m_pulse[ch] = 0;
      end else begin
        bit exp_now;
        exp_now = 0;
        if (m_run[ch]) begin
          m_elapsed[ch]++;
          if (m_elapsed[ch] == m_period(ch)) begin
            exp_now = 1;
            if (m_periodic[ch]) m_elapsed[ch] = 0;
            else begin m_run[ch] = 0; m_done[ch] = 1; end
          end
        end
        m_pulse[ch] = exp_now;
        if (exp_now) begin
          if (m_pending[ch] && !ack[ch]) m_overrun[ch] = 1;
          m_pending[ch] = 1;
        end else if (ack[ch]) begin
          m_pending[ch] = 0;
          m_overrun[ch] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0] e_pulse, e_pend, e_ovr;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_pulse[ch] = m_pulse[ch];
      e_pend[ch]  = m_pending[ch];
      e_ovr[ch]   = m_overrun[ch];
    end
    check("irq_pulse", 32'(irq_pulse), 32'(e_pulse));
    check("irq_pending", 32'(irq_pending), 32'(e_pend));
    check("irq_overrun", 32'(irq_overrun), 32'(e_ovr));
    check("irq", 32'(irq), 32'(|e_pend));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rd_ch = CH_W'(ch);
      #1;
      check($sformatf("rd_count[%0d]", ch), 32'(rd_count), 32'(m_count(ch)));
    end
  endtask

  task automatic step();
    bit r, we, wper, wrun;
    int wch, wrl, wps;
    logic [NUM_CH-1:0] ack;
    r = reset; we = wr_en; wch = int'(wr_ch); wrl = int'(wr_reload);
    wps = int'(wr_prescale); wper = wr_periodic; wrun = wr_run; ack = irq_ack;
    @(posedge clk);
    model_edge(r, we, wch, wrl, wps, wper, wrun, ack);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_write(input int ch, input int rl, input int ps, input bit per, input bit run);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_reload = CNT_W'(rl);
    wr_prescale = PRE_W'(ps); wr_periodic = per; wr_run = run;
  endtask

  task automatic do_write(input int ch, input int rl, input int ps, input bit per, input bit run);
    set_write(ch, rl, ps, per, run);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int first, npulse, found;
    reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_reload = '0; wr_prescale = '0;
    wr_periodic = 1'b0; wr_run = 1'b0; irq_ack = '0; rd_ch = '0;
    step(); step();
    reset = 1'b0;
    idle(20);

    // ch0 periodic reload 3, prescale 0: first pulse 4 cycles after write
    do_write(0, 3, 0, 1, 1);
    first = 0; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (irq_pulse[0]) begin npulse++; if (first == 0) first = i; end
    end
    check("ch0_first_pulse", 32'(first), 32'd4);
    check("ch0_pulse_count", 32'(npulse), 32'd3);
    check("ch0_overrun", 32'(irq_overrun[0]), 32'd1);

    // ch1 one-shot reload 2, prescale 4: single pulse at 15
    do_write(1, 2, 4, 0, 1);
    first = 0; npulse = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (irq_pulse[1]) begin npulse++; if (first == 0) first = i; end
    end
    check("ch1_first_pulse", 32'(first), 32'd15);
    check("ch1_pulse_count", 32'(npulse), 32'd1);
    irq_ack = 4'b0010; step(); irq_ack = '0;
    check("ch1_ack_clears", 32'(irq_pending[1]), 32'd0);

    // ch2/ch3 periodic, independent spacing; stop ch0 first
    do_write(0, 3, 0, 1, 0);
    irq_ack = 4'b0001; step(); irq_ack = '0;
    do_write(2, 5, 0, 1, 1);
    do_write(3, 7, 0, 1, 1);
    idle(30);
    do_write(2, 5, 0, 1, 0);
    check("irq_ch3_still_pending", 32'(irq), 32'd1);
    irq_ack = 4'b1000; step(); irq_ack = '0;
    idle(3);

    // ack coincident with ch0 expiry
    do_write(0, 3, 0, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_elapsed[0] == m_period(0) - 1) found = 1;
      else step();
    end
    check("ack_expiry_found", 32'(found), 32'd1);
    irq_ack = 4'b0001; step(); irq_ack = '0;
    check("ack_on_expiry_pulse", 32'(irq_pulse[0]), 32'd1);
    check("ack_on_expiry_pending", 32'(irq_pending[0]), 32'd1);

    // write on the expiry tick of ch0: no pulse, count reloads
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_elapsed[0] == m_period(0) - 1) found = 1;
      else step();
    end
    check("wr_tick_found", 32'(found), 32'd1);
    do_write(0, 3, 0, 1, 1);
    check("wr_tick_no_pulse", 32'(irq_pulse[0]), 32'd0);

    // stop write freezes count at reload
    do_write(3, 9, 0, 1, 0);
    idle(5);
    rd_ch = 2'd3; #1;
    check("frozen_count", 32'(rd_count), 32'd9);

    // reset mid-count
    idle(2);
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_pending", 32'(irq_pending), 32'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_write(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
      for (int ch = 0; ch < NUM_CH; ch++) irq_ack[ch] = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
      wr_en = 1'b0; irq_ack = '0; reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
